// File: rtl/backtrack_ctrl_if.sv
// Trace-table and variable-assignment signals seen by the backtrack engine.
// master = backtrack_ctrl side, slave = trace_table / assignment-table side.
interface backtrack_ctrl_if #(
    parameter int VAR_W = 9
);
    logic             tt_empty;
    logic             tt_type_out;
    logic             tt_val_out;
    logic [VAR_W-1:0] tt_variable_out;
    logic             tt_pop;
    logic             tt_push;
    logic             tt_type;
    logic             tt_val;
    logic [VAR_W-1:0] tt_variable;
    logic             va_clear;
    logic             va_set;
    logic [VAR_W-1:0] va_var;
    logic             va_val;

    modport master (
        input  tt_empty, tt_type_out, tt_val_out, tt_variable_out,
        output tt_pop, tt_push, tt_type, tt_val, tt_variable,
        output va_clear, va_set, va_var, va_val
    );

    modport slave (
        output tt_empty, tt_type_out, tt_val_out, tt_variable_out,
        input  tt_pop, tt_push, tt_type, tt_val, tt_variable,
        input  va_clear, va_set, va_var, va_val
    );
endinterface

// File: rtl/backtrack_ctrl.sv
// DPLL backtrack engine: pops the trail down to the latest decision and re-pushes it flipped.
// Optional statistics outputs (bt_count, max_pops) exist only when BACKTRACK_STATS_EN is defined.
module backtrack_ctrl #(
    parameter  int VAR_W = 9,
    parameter  int DEPTH = 512,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             unsat,
    output logic [CNT_W-1:0] pop_count,
`ifdef BACKTRACK_STATS_EN
    output logic [31:0]      bt_count,
    output logic [CNT_W-1:0] max_pops,
`endif
    backtrack_ctrl_if.master tt
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLIP,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    state_t             state_q, state_d;
    logic               found_q, found_d;
    logic [VAR_W-1:0]   saved_var_q, saved_var_d;
    logic               saved_val_q, saved_val_d;
    logic [CNT_W-1:0]   pop_count_q, pop_count_d;

    assign pop_count = pop_count_q;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d        = state_q;
        found_d        = found_q;
        saved_var_d    = saved_var_q;
        saved_val_d    = saved_val_q;
        pop_count_d    = pop_count_q;
        busy           = (state_q != IDLE);
        done           = 1'b0;
        unsat          = 1'b0;
        tt.tt_pop      = 1'b0;
        tt.tt_push     = 1'b0;
        tt.tt_type     = 1'b0;
        tt.tt_val      = 1'b0;
        tt.tt_variable = '0;
        tt.va_clear    = 1'b0;
        tt.va_set      = 1'b0;
        tt.va_var      = '0;
        tt.va_val      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    pop_count_d = '0;
                    found_d     = 1'b0;
                end
            end
            SCAN: begin
                if (tt.tt_empty) begin
                    state_d = FIN;
                end else begin
                    tt.tt_pop   = 1'b1;
                    tt.va_clear = 1'b1;
                    tt.va_var   = tt.tt_variable_out;
                    if (pop_count_q != CNT_MAX) begin
                        pop_count_d = pop_count_q + 1'b1;
                    end
                    // A decision entry ends the scan; it is popped here and re-pushed in FLIP.
                    if (!tt.tt_type_out) begin
                        saved_var_d = tt.tt_variable_out;
                        saved_val_d = tt.tt_val_out;
                        found_d     = 1'b1;
                        state_d     = FLIP;
                    end
                end
            end
            FLIP: begin
                tt.tt_push     = 1'b1;
                tt.tt_type     = 1'b1;
                tt.tt_val      = ~saved_val_q;
                tt.tt_variable = saved_var_q;
                tt.va_set      = 1'b1;
                tt.va_var      = saved_var_q;
                tt.va_val      = ~saved_val_q;
                state_d        = FIN;
            end
            FIN: begin
                done    = 1'b1;
                unsat   = ~found_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= IDLE;
            found_q     <= 1'b0;
            saved_var_q <= '0;
            saved_val_q <= 1'b0;
            pop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            found_q     <= found_d;
            saved_var_q <= saved_var_d;
            saved_val_q <= saved_val_d;
            pop_count_q <= pop_count_d;
        end
    end

`ifdef BACKTRACK_STATS_EN
    logic [31:0]      bt_count_q, bt_count_d;
    logic [CNT_W-1:0] max_pops_q, max_pops_d;

    assign bt_count = bt_count_q;
    assign max_pops = max_pops_q;

    always_comb begin
        bt_count_d = bt_count_q;
        max_pops_d = max_pops_q;
        if (state_q == FLIP && bt_count_q != 32'hFFFF_FFFF) begin
            bt_count_d = bt_count_q + 32'd1;
        end
        // pop_count only grows within a backtrack, so tracking it continuously captures each final value.
        if (pop_count_q > max_pops_q) begin
            max_pops_d = pop_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bt_count_q <= '0;
            max_pops_q <= '0;
        end else begin
            bt_count_q <= bt_count_d;
            max_pops_q <= max_pops_d;
        end
    end
`endif

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Bench for backtrack_ctrl: a queue models trace_table, expected behaviour is derived from the trail contents.
// Define BACKTRACK_STATS_EN to also check bt_count / max_pops.
module tb_backtrack_ctrl;
    localparam int VAR_W = 9;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             t;
        logic             v;
        logic [VAR_W-1:0] var_idx;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b1;
    logic             busy, done, unsat;
    logic [CNT_W-1:0] pop_count;
`ifdef BACKTRACK_STATS_EN
    logic [31:0]      bt_count;
    logic [CNT_W-1:0] max_pops;
`endif

    backtrack_ctrl_if #(.VAR_W(VAR_W)) bus ();

    backtrack_ctrl #(.VAR_W(VAR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .unsat    (unsat),
        .pop_count(pop_count),
`ifdef BACKTRACK_STATS_EN
        .bt_count (bt_count),
        .max_pops (max_pops),
`endif
        .tt       (bus)
    );

    always #5 clk = ~clk;

    entry_t trail[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     exp_bt  = 0;
    int     exp_max = 0;

    // Trace-table model: top of stack is the back of the queue.
    task automatic present();
        if (trail.size() == 0) begin
            bus.tt_empty        = 1'b1;
            bus.tt_type_out     = 1'b0;
            bus.tt_val_out      = 1'b0;
            bus.tt_variable_out = '0;
        end else begin
            bus.tt_empty        = 1'b0;
            bus.tt_type_out     = trail[trail.size()-1].t;
            bus.tt_val_out      = trail[trail.size()-1].v;
            bus.tt_variable_out = trail[trail.size()-1].var_idx;
        end
    endtask

    initial begin
        logic   do_pop, do_push;
        entry_t pe;
        present();
        forever begin
            @(negedge clk);
            do_pop  = bus.tt_pop;
            do_push = bus.tt_push;
            pe      = '{t: bus.tt_type, v: bus.tt_val, var_idx: bus.tt_variable};
            @(posedge clk);
            #1;
            if (do_pop && trail.size() > 0) void'(trail.pop_back());
            if (do_push) trail.push_back(pe);
            present();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] strobes();
        return {busy, done, unsat, bus.tt_pop, bus.tt_push, bus.va_clear, bus.va_set,
                bus.tt_type, bus.tt_val, bus.va_val};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " strobes"}, 32'(strobes()), 32'd0);
        check({tag, " va_var"}, 32'(bus.va_var), 32'd0);
        check({tag, " tt_variable"}, 32'(bus.tt_variable), 32'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef BACKTRACK_STATS_EN
        check({tag, " bt_count"}, bt_count, 32'(exp_bt));
        check({tag, " max_pops"}, 32'(max_pops), 32'(exp_max));
`endif
    endtask

    task automatic load(input entry_t e[$]);
        trail = e;
        tick();
    endtask

    // Run one backtrack on the current trail and compare every cycle against the trail-derived expectation.
    task automatic run_bt(input string tag, input bit pulse_start);
        entry_t popped[$];
        entry_t after[$];
        entry_t flip;
        bit     found = 1'b0;
        int     pops, exp_pc;
        logic [9:0]       e_vec;
        logic [VAR_W-1:0] e_va_var, e_tt_var;
        bit               ok;

        flip = '0;
        for (int i = trail.size() - 1; i >= 0; i--) begin
            popped.push_back(trail[i]);
            if (!trail[i].t) begin
                found = 1'b1;
                flip  = trail[i];
                break;
            end
        end
        pops   = popped.size();
        exp_pc = (pops > DEPTH) ? DEPTH : pops;
        after  = trail;
        for (int i = 0; i < pops; i++) void'(after.pop_back());
        if (found) after.push_back('{t: 1'b1, v: ~flip.v, var_idx: flip.var_idx});

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= pops + 2; c++) begin
            bit e_done = (c == pops + 2);
            bit e_pop  = (c <= pops);
            bit e_push = found && (c == pops + 1);
            e_vec    = {1'b1, e_done, e_done && !found, e_pop, e_push, e_pop, e_push,
                        e_push, e_push && !flip.v, e_push && !flip.v};
            e_va_var = e_pop ? popped[c-1].var_idx : (e_push ? flip.var_idx : '0);
            e_tt_var = e_push ? flip.var_idx : '0;
            check($sformatf("%s c%0d strobes", tag, c), 32'(strobes()), 32'(e_vec));
            check($sformatf("%s c%0d va_var", tag, c), 32'(bus.va_var), 32'(e_va_var));
            check($sformatf("%s c%0d tt_variable", tag, c), 32'(bus.tt_variable), 32'(e_tt_var));
            if (e_done) check($sformatf("%s pop_count at done", tag), 32'(pop_count), 32'(exp_pc));
            if (pulse_start && c <= pops + 1) start = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
        end

        if (found) exp_bt++;
        if (exp_pc > exp_max) exp_max = exp_pc;
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check_idle({tag, " after"});
        check({tag, " pop_count held"}, 32'(pop_count), 32'(exp_pc));
        ok = (trail.size() == after.size());
        if (ok) foreach (after[i]) if (trail[i] !== after[i]) ok = 1'b0;
        check({tag, " trail contents"}, 32'(ok), 32'd1);
        check_stats(tag);
    endtask

    initial begin
        entry_t scen2[$];
        entry_t e[$];
        scen2 = '{'{t: 1'b0, v: 1'b1, var_idx: 9'd5},
                  '{t: 1'b1, v: 1'b0, var_idx: 9'd7},
                  '{t: 1'b1, v: 1'b1, var_idx: 9'd9}};

        // Reset held two cycles with start asserted throughout.
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset pop_count", 32'(pop_count), 32'd0);
        check_idle("reset");
        check_stats("reset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post-reset busy", 32'(busy), 32'd0);
        check_idle("post-reset");

        load(scen2);
        run_bt("scen2", 1'b0);

        e = '{'{t: 1'b1, v: 1'b1, var_idx: 9'd1}, '{t: 1'b1, v: 1'b0, var_idx: 9'd2}};
        load(e);
        run_bt("no_decision", 1'b0);

        e.delete();
        load(e);
        run_bt("empty", 1'b0);

        // More F entries than DEPTH: pop_count must saturate.
        e.delete();
        for (int i = 0; i < DEPTH + 3; i++) e.push_back('{t: 1'b1, v: i[0], var_idx: 9'(i + 20)});
        load(e);
        run_bt("saturate", 1'b0);

        // Reset during the second SCAN cycle, with a start pulse while busy beforehand.
        load(scen2);
        start = 1'b1;
        tick();
        start = 1'b1;
        check("midrst c1 busy", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        check("midrst c2 pop", 32'(bus.tt_pop), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_bt  = 0;
        exp_max = 0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst pop_count", 32'(pop_count), 32'd0);
        check_idle("midrst");
        tick();
        check_idle("midrst+1");
        check("midrst trail size", 32'(trail.size()), 32'd1);
        check_stats("midrst");

        load(scen2);
        run_bt("stats run1", 1'b1);
        load(scen2);
        run_bt("stats run2", 1'b0);

        for (int r = 0; r < 25; r++) begin
            int len = $urandom_range(0, 11);
            e.delete();
            for (int i = 0; i < len; i++) begin
                e.push_back('{t: 1'($urandom_range(0, 3) != 0), v: 1'($urandom_range(0, 1)),
                              var_idx: 9'($urandom_range(0, 511))});
            end
            load(e);
            run_bt($sformatf("rand%0d", r), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
